// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   InstBus / InstAddrBus : instruction and address widths
//   INST_NOP              : bubble instruction shown to decode when nothing is held
//   RESET_PC_DEF          : first fetch address after reset
//   ifu_state_e           : fetch FSM state encodings
package ysyx_23060332_ifu_pkg;

  localparam int unsigned InstBus     = 32;
  localparam int unsigned InstAddrBus = 32;

  localparam logic [InstBus-1:0]     INST_NOP     = 32'h0000_0013;
  localparam logic [InstAddrBus-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_S_IDLE = 2'd0,
    IFU_S_REQ  = 2'd1,
    IFU_S_WAIT = 2'd2,
    IFU_S_OUT  = 2'd3
  } ifu_state_e;

  // Sequential PC step; wraps silently at 2^32.
  function automatic logic [InstAddrBus-1:0] pc_step(input logic [InstAddrBus-1:0] pc);
    return pc + InstAddrBus'(4);
  endfunction

endpackage

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: holds the PC, issues one outstanding fetch at a time
// to instruction memory, buffers the returned instruction and hands it to
// decode with a valid/ready handshake. Redirects from execute discard any
// wrong-path fetch still in flight.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   imem_req_valid/addr/ready      fetch request channel
//   imem_rsp_valid/data            fetch response (one per accepted request)
//   jump_en, jump_addr             redirect from execute (one-cycle pulse)
//   inst_valid/ready, inst_o,
//   inst_addr_o                    instruction and its PC to decode
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [InstBus-1:0]     NOP_INST = INST_NOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  output logic [InstAddrBus-1:0] imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [InstBus-1:0]     imem_rsp_data,
  input  logic                   jump_en,
  input  logic [InstAddrBus-1:0] jump_addr,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_addr_o
);

  ifu_state_e             r_state;
  logic [InstAddrBus-1:0] r_fetch_pc;
  logic [InstAddrBus-1:0] r_redirect_pc;
  logic                   r_kill;
  logic                   r_req_valid;
  logic                   r_inst_valid;
  logic [InstBus-1:0]     r_inst;
  logic [InstAddrBus-1:0] r_inst_addr;

  // Request address is the held PC; it only moves outside S_REQ.
  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign inst_valid     = r_inst_valid;
  assign inst_o         = r_inst;
  assign inst_addr_o    = r_inst_addr;

  // Fetch FSM and one-entry instruction buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IFU_S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_redirect_pc <= '0;
      r_kill        <= 1'b0;
      r_req_valid   <= 1'b0;
      r_inst_valid  <= 1'b0;
      r_inst        <= NOP_INST;
      r_inst_addr   <= RESET_PC;
    end else begin
      unique case (r_state)
        IFU_S_IDLE: begin
          if (jump_en) r_fetch_pc <= jump_addr;
          r_req_valid <= 1'b1;
          r_state     <= IFU_S_REQ;
        end

        IFU_S_REQ: begin
          // A redirect here cannot retract the request; remember the target
          // and drop the response when it arrives.
          if (jump_en) begin
            r_redirect_pc <= jump_addr;
            r_kill        <= 1'b1;
          end
          if (imem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= IFU_S_WAIT;
          end
        end

        IFU_S_WAIT: begin
          if (imem_rsp_valid) begin
            // A same-cycle jump is newer than any pending kill target.
            if (jump_en) begin
              r_fetch_pc  <= jump_addr;
              r_kill      <= 1'b0;
              r_req_valid <= 1'b1;
              r_state     <= IFU_S_REQ;
            end else if (r_kill) begin
              r_fetch_pc  <= r_redirect_pc;
              r_kill      <= 1'b0;
              r_req_valid <= 1'b1;
              r_state     <= IFU_S_REQ;
            end else begin
              r_inst       <= imem_rsp_data;
              r_inst_addr  <= r_fetch_pc;
              r_inst_valid <= 1'b1;
              r_state      <= IFU_S_OUT;
            end
          end else if (jump_en) begin
            r_redirect_pc <= jump_addr;
            r_kill        <= 1'b1;
          end
        end

        IFU_S_OUT: begin
          // Jump wins over a simultaneous decode handshake.
          if (jump_en) begin
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_fetch_pc   <= jump_addr;
            r_req_valid  <= 1'b1;
            r_state      <= IFU_S_REQ;
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_fetch_pc   <= pc_step(r_fetch_pc);
            r_req_valid  <= 1'b1;
            r_state      <= IFU_S_REQ;
          end
        end

        default: r_state <= IFU_S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed testbench for the instruction fetch unit.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  int n_cmp;
  int n_bad;

  ysyx_23060332_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    jump_en        = 1'b0;
    jump_addr      = 32'h0;
    inst_ready     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a request; ok=0 on timeout.
  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Accept the pending request with zero wait and return data next cycle.
  task automatic serve(input logic [31:0] data, output logic ok, output logic [31:0] addr);
    wait_req(ok);
    addr = imem_req_addr;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_inst_valid got %0b want 0", inst_valid); end
    n_cmp++;
    if (inst_o !== NOP) begin n_bad++; $display("FAIL reset_inst_o got %h want %h", inst_o, NOP); end
    n_cmp++;
    if (inst_addr_o !== RST_PC) begin n_bad++; $display("FAIL reset_inst_addr got %h want %h", inst_addr_o, RST_PC); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_bad++; $display("FAIL first_req got v=%0b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    logic        ok;
    logic [31:0] a;
    logic [31:0] d;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 32'h1000_0000 + 32'(i);
      serve(d, ok, a);
      n_cmp++;
      if (!ok || a !== RST_PC + 32'(4 * i)) begin
        n_bad++; $display("FAIL zw_req_addr[%0d] got %h ok=%0b want %h", i, a, ok, RST_PC + 32'(4 * i));
      end
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_o !== d || inst_addr_o !== RST_PC + 32'(4 * i)) begin
        n_bad++; $display("FAIL zw_out[%0d] got v=%0b i=%h a=%h want v=1 i=%h a=%h",
                          i, inst_valid, inst_o, inst_addr_o, d, RST_PC + 32'(4 * i));
      end
      tick();
      n_cmp++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
        n_bad++; $display("FAIL zw_after_hs[%0d] got iv=%0b rv=%0b want iv=0 rv=1", i, inst_valid, imem_req_valid);
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic        ok;
    logic [31:0] a;
    do_reset();
    serve(32'h0010_0093, ok, a);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_o !== 32'h0010_0093 || inst_addr_o !== RST_PC || imem_req_valid !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v=%0b i=%h a=%h rv=%0b want v=1 i=00100093 a=%h rv=0",
                          i, inst_valid, inst_o, inst_addr_o, imem_req_valid, RST_PC);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      n_bad++; $display("FAIL bp_release got iv=%0b rv=%0b a=%h want iv=0 rv=1 a=80000004",
                        inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_mem_stall();
    logic        ok;
    logic [31:0] a;
    do_reset();
    serve(32'h0000_0001, ok, a);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
        n_bad++; $display("FAIL stall_req[%0d] got v=%0b a=%h want v=1 a=80000004", i, imem_req_valid, imem_req_addr);
      end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        n_bad++; $display("FAIL stall_wait[%0d] got iv=%0b rv=%0b want 0 0", i, inst_valid, imem_req_valid);
      end
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_beef;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_o !== 32'hdead_beef || inst_addr_o !== 32'h8000_0004) begin
      n_bad++; $display("FAIL stall_out got v=%0b i=%h a=%h want v=1 i=deadbeef a=80000004",
                        inst_valid, inst_o, inst_addr_o);
    end
  endtask

  task automatic test_jump_wait();
    logic ok;
    do_reset();
    wait_req(ok);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    jump_en = 1'b1; jump_addr = 32'h8000_0100;
    tick();
    jump_en = 1'b0;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      n_bad++; $display("FAIL jw_single got iv=%0b rv=%0b a=%h want iv=0 rv=1 a=80000100",
                        inst_valid, imem_req_valid, imem_req_addr);
    end
    // Two jumps while waiting: the later target wins.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    jump_en = 1'b1; jump_addr = 32'h8000_0300;
    tick();
    jump_addr = 32'h8000_0200;
    tick();
    jump_en = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      n_bad++; $display("FAIL jw_double got iv=%0b rv=%0b a=%h want iv=0 rv=1 a=80000200",
                        inst_valid, imem_req_valid, imem_req_addr);
    end
    // Jump during S_REQ: request address unchanged, response dropped.
    jump_en = 1'b1; jump_addr = 32'h8000_0400;
    tick();
    jump_en = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      n_bad++; $display("FAIL jreq_hold got v=%0b a=%h want v=1 a=80000200", imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_3333;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin
      n_bad++; $display("FAIL jreq_redirect got iv=%0b rv=%0b a=%h want iv=0 rv=1 a=80000400",
                        inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_jump_coincident();
    logic        ok;
    logic [31:0] a;
    // Currently in S_REQ at 0x80000400 from the previous test.
    serve(32'h4444_4444, ok, a);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_addr_o !== 32'h8000_0400) begin
      n_bad++; $display("FAIL jc_pre got v=%0b a=%h want v=1 a=80000400", inst_valid, inst_addr_o);
    end
    jump_en = 1'b1; jump_addr = 32'h8000_0800; inst_ready = 1'b1;
    tick();
    jump_en = 1'b0; inst_ready = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || inst_o !== NOP || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0800) begin
      n_bad++; $display("FAIL jc_out got iv=%0b i=%h rv=%0b a=%h want iv=0 i=%h rv=1 a=80000800",
                        inst_valid, inst_o, imem_req_valid, imem_req_addr, NOP);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_5555;
    jump_en = 1'b1; jump_addr = 32'h8000_0a00;
    tick();
    imem_rsp_valid = 1'b0; jump_en = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0a00) begin
      n_bad++; $display("FAIL jc_wait got iv=%0b rv=%0b a=%h want iv=0 rv=1 a=80000a00",
                        inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_async_reset();
    logic        ok;
    logic [31:0] a;
    // Reset while an instruction is held in S_OUT.
    do_reset();
    serve(32'h6666_6666, ok, a);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || inst_o !== NOP || inst_addr_o !== RST_PC) begin
      n_bad++; $display("FAIL areset_out got v=%0b i=%h a=%h want v=0 i=%h a=%h",
                        inst_valid, inst_o, inst_addr_o, NOP, RST_PC);
    end
    tick();
    rst_n = 1'b1;
    // Walk to 0x80000004 and reset while waiting on the response.
    serve(32'h7777_7777, ok, a);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_req(ok);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
      n_bad++; $display("FAIL areset_wait got rv=%0b iv=%0b a=%h want rv=0 iv=0 a=%h",
                        imem_req_valid, inst_valid, imem_req_addr, RST_PC);
    end
    tick();
    rst_n = 1'b1;
    // A stale response right after release must be ignored.
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8888_8888;
    tick();
    imem_rsp_valid = 1'b0;
    wait_req(ok);
    n_cmp++;
    if (!ok || imem_req_addr !== RST_PC || inst_valid !== 1'b0) begin
      n_bad++; $display("FAIL areset_resume got ok=%0b a=%h iv=%0b want ok=1 a=%h iv=0",
                        ok, imem_req_addr, inst_valid, RST_PC);
    end
  endtask

  task automatic test_wrap();
    logic        ok;
    logic [31:0] a;
    do_reset();
    // Jump taken in S_IDLE sets the first fetch address.
    jump_en = 1'b1; jump_addr = 32'hffff_fffc;
    tick();
    jump_en = 1'b0;
    serve(32'h9999_9999, ok, a);
    n_cmp++;
    if (!ok || a !== 32'hffff_fffc || inst_addr_o !== 32'hffff_fffc) begin
      n_bad++; $display("FAIL wrap_pre got ok=%0b req=%h out=%h want req=fffffffc out=fffffffc", ok, a, inst_addr_o);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
      n_bad++; $display("FAIL wrap_addr got v=%0b a=%h want v=1 a=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_mem_stall();
    test_jump_wait();
    test_jump_coincident();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
